// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes that
// match the ALU control encoding, the FSM state type and the iteration count.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1100;

    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // True for the four codes this unit executes; everything else is ALU work.
    function automatic logic op_valid(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO. One shared 64-bit
// shift register and one 33-bit add/subtract serve both shift-add multiply
// and restoring divide; signs are stripped at launch and restored in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state;
    logic [4:0]         cnt;
    logic [2*WIDTH-1:0] acc;      // mul: {partial hi, multiplier}; div: {rem, dividend/quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic               is_mul;
    logic               res_neg;
    logic               rem_neg;
    logic               div0;

    logic               signed_op;
    logic               mul_op;
    logic               accept;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     alu_a;
    logic [WIDTH:0]     alu_b;
    logic [WIDTH:0]     alu_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != IDLE);

    // Launch decode and operand magnitudes.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        mul_op    = (op == OP_MULT) || (op == OP_MULTU);
        accept    = (state == IDLE) && start && op_valid(op);
        mag1      = (signed_op && op1[WIDTH-1]) ? (~op1 + 1'b1) : op1;
        mag2      = (signed_op && op2[WIDTH-1]) ? (~op2 + 1'b1) : op2;
    end

    // One iteration: add the multiplicand on a set multiplier bit, or trial
    // subtract the divisor from the shifted remainder.
    always_comb begin
        alu_a    = is_mul ? {1'b0, acc[2*WIDTH-1:WIDTH]} : acc[2*WIDTH-1:WIDTH-1];
        alu_b    = {1'b0, opnd};
        alu_sum  = is_mul ? (alu_a + alu_b) : (alu_a - alu_b);
        acc_step = acc;
        if (is_mul) begin
            acc_step = acc[0] ? {alu_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        end else begin
            acc_step = !alu_sum[WIDTH] ? {alu_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                       : {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    // Sign restoration applied in FIX. A zero divisor leaves the remainder
    // equal to the dividend, so only the quotient needs overriding.
    always_comb begin
        prod_fix = res_neg ? (~acc + 1'b1) : acc;
        quo_fix  = div0 ? '1 : (res_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0]);
        rem_fix  = rem_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_mul  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            div0    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RUN;
                        cnt     <= 5'(ITERATIONS - 1);
                        acc     <= {{WIDTH{1'b0}}, mag1};
                        opnd    <= mag2;
                        is_mul  <= mul_op;
                        res_neg <= signed_op && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                        rem_neg <= signed_op && op1[WIDTH-1];
                        div0    <= !mul_op && (op2 == '0);
                    end else if (!start) begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) state <= FIX;
                end
                FIX: begin
                    if (is_mul) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed products, quotients and
// remainders, latency/done checks, MT* hazards and mid-operation reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op1(op1), .op2(op2),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive start for exactly one edge (E0); returns at E0+1.
    task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; op1 = a; op2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
    endtask

    // Count cycles with busy high (bounded) and done pulses seen while busy.
    task automatic wait_idle(output int n, output int d);
        n = 0; d = 0;
        while (busy && n < 60) begin
            if (done) d++;
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_chk(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n, d;
        launch(o, a, b);
        wait_idle(n, d);
        chk({tag, "_lat"}, 64'(n), 64'd33);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hilo"}, {hi, lo}, {ehi, elo});
    endtask

    initial begin
        int n, d;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULT -3 * 5 with full latency and done-pulse checks
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        chk("mult_hold_e0", {hi, lo}, 64'd0);
        wait_idle(n, d);
        chk("mult_lat", 64'(n), 64'd33);
        chk("mult_done_early", 64'(d), 64'd0);
        chk("mult_done", 64'(done), 64'd1);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        @(posedge clk);
        #1;
        chk("mult_done_fall", 64'(done), 64'd0);

        run_chk("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        // Back-to-back: next launch lands in the done cycle
        run_chk("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_chk("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_chk("divu_z", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_chk("div_z", OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);

        // MTLO and a second start mid-RUN are both ignored
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        mtlo = 1'b1; wdata = 32'h1234; start = 1'b1; op = OP_MULT; op1 = 32'd9; op2 = 32'd9;
        @(posedge clk);
        #1;
        mtlo = 1'b0; start = 1'b0;
        chk("midrun_hold", {hi, lo}, 64'hFFFF_FFF8_FFFF_FFFF);
        wait_idle(n, d);
        chk("midrun_hilo", {hi, lo}, {32'd2, 32'd14});
        @(posedge clk);
        #1;
        chk("midrun_noqueue", 64'(busy), 64'd0);

        // MTHI + MTLO together in IDLE
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD;
        @(posedge clk);
        #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both", {hi, lo}, {32'hABCD, 32'hABCD});

        // Unsupported op stays IDLE
        launch(4'b0011, 32'd1, 32'd1);
        chk("badop_idle", 64'(busy), 64'd0);
        chk("badop_hilo", {hi, lo}, {32'hABCD, 32'hABCD});

        // MTLO with an accepted start loses to start
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; op1 = 32'd2; op2 = 32'd3; mtlo = 1'b1; wdata = 32'h5555;
        @(posedge clk);
        #1;
        start = 1'b0; mtlo = 1'b0;
        chk("mt_start_lo", 64'(lo), 64'hABCD);
        wait_idle(n, d);
        chk("mt_start_res", {hi, lo}, {32'd0, 32'd6});

        // Reset asserted at E10 of a DIV aborts it
        launch(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_chk("after_rst", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
